// File: rtl/binary_divider_16bit.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Start loads operands; Done rises N edges later (same edge for a zero divisor) and holds until Start.
module binary_divider_16bit #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         Busy,
  output logic         Done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [M:0] CNT_INIT = (M+1)'(N);
  localparam logic [M:0] CNT_ONE  = (M+1)'(1);

  logic [1:0]   state_q, state_d;
  logic [2*N:0] acc_q, acc_d;
  logic [N-1:0] dvs_q, dvs_d;
  logic [M:0]   cnt_q, cnt_d;
  logic         dz_q, dz_d;

  logic [2*N:0] shl;
  logic [N:0]   trial;
  logic [N-1:0] lo;

  always_comb begin
    shl     = acc_q << 1;
    trial   = shl[2*N:N] - {1'b0, dvs_q};
    // shl[0] is always zero, so OR-ing places the new quotient bit
    lo      = shl[N-1:0] | {{(N-1){1'b0}}, ~trial[N]};
    state_d = state_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          dvs_d = divisor;
          cnt_d = CNT_INIT;
          if (divisor == '0) begin
            // Preload the divide-by-zero result: all-ones quotient, dividend as remainder
            acc_d   = {1'b0, dividend, {N{1'b1}}};
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{(N+1){1'b0}}, dividend};
            dz_d    = 1'b0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = trial[N] ? {shl[2*N:N], lo} : {trial, lo};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= CNT_INIT;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy        = (state_q == S_BUSY);
  assign Done        = (state_q == S_DONE);
  assign div_by_zero = Done & dz_q;
  assign quotient    = Done ? acc_q[N-1:0]   : '0;
  assign remainder   = Done ? acc_q[2*N-1:N] : '0;

endmodule

// File: tb/tb_binary_divider_16bit.sv
// Randomised and directed bench for binary_divider_16bit against an arithmetic reference model.
module tb_binary_divider_16bit;

  logic        clock;
  logic        Reset;
  logic        Start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        Busy;
  logic        Done;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int errs   = 0;
  int checks = 0;

  binary_divider_16bit dut (
    .clock       (clock),
    .Reset       (Reset),
    .Start       (Start),
    .dividend    (dividend),
    .divisor     (divisor),
    .Busy        (Busy),
    .Done        (Done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a busy countdown plus results from plain / and %.
  logic        m_busy, m_done, m_dz;
  logic [15:0] m_q, m_r, p_q, p_r;
  int          left;
  int          ncyc = 0;

  always @(posedge clock) begin
    ncyc++;
    if (!Reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0; left = 0;
    end else if (!m_busy && Start) begin
      if (divisor == 16'd0) begin
        m_done = 1; m_dz = 1; m_q = 16'hFFFF; m_r = dividend;
      end else begin
        m_busy = 1; m_done = 0; m_dz = 0; left = 16;
        p_q = dividend / divisor;
        p_r = dividend % divisor;
      end
    end else if (m_busy) begin
      left--;
      if (left == 0) begin
        m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
      end
    end
  end

  always @(negedge clock) begin
    if (ncyc > 0) begin
      chk("busy", Busy, m_busy);
      chk("done", Done, m_done);
      chk("dz", div_by_zero, m_done & m_dz);
      chk("quotient", quotient, m_done ? m_q : 16'd0);
      chk("remainder", remainder, m_done ? m_r : 16'd0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    Start    = 1'b1;
    cyc();
    Start    = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!Done && lat < 40) begin
      cyc();
      lat++;
    end
    chk("done_seen", Done, 1);
    chk("latency", lat, exp_lat);
  endtask

  task automatic check_result(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) begin
      chk("dz_q", quotient, 16'hFFFF);
      chk("dz_r", remainder, a);
      chk("dz_flag", div_by_zero, 1);
    end else begin
      chk("inv_sum", quotient * b + remainder, a);
      chk("inv_rem_lt", remainder < b, 1);
      chk("dz_clear", div_by_zero, 0);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) cyc();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_q", quotient, 0);
    Reset = 1'b1;
    repeat (3) cyc();
    chk("idle_done", Done, 0);
    chk("idle_r", remainder, 0);

    launch(16'd100, 16'd7);
    wait_done(16);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);
    repeat (3) cyc();
    chk("hold_q", quotient, 14);
    chk("hold_done", Done, 1);

    launch(16'hFFFF, 16'd1);     wait_done(16);
    chk("q_max_1", quotient, 16'hFFFF); chk("r_max_1", remainder, 0);
    launch(16'd5, 16'd10);       wait_done(16);
    chk("q_5_10", quotient, 0);         chk("r_5_10", remainder, 5);
    launch(16'hFFFF, 16'hFFFF);  wait_done(16);
    chk("q_max_max", quotient, 1);      chk("r_max_max", remainder, 0);
    launch(16'd0, 16'd9);        wait_done(16);
    chk("q_zero", quotient, 0);         chk("r_zero", remainder, 0);

    launch(16'd1234, 16'd0);     wait_done(0);
    chk("q_dz", quotient, 16'hFFFF);    chk("r_dz", remainder, 1234);
    chk("flag_dz", div_by_zero, 1);
    launch(16'd50, 16'd6);       wait_done(16);
    chk("flag_cleared", div_by_zero, 0);
    chk("q_50_6", quotient, 8);         chk("r_50_6", remainder, 2);

    // Start pulsed mid-division must be ignored
    launch(16'd100, 16'd7);
    repeat (4) cyc();
    dividend = 16'd999; divisor = 16'd3; Start = 1'b1;
    cyc();
    Start = 1'b0;
    wait_done(11);
    chk("ign_q", quotient, 14);
    chk("ign_r", remainder, 2);

    // Reset in the middle of a division
    launch(16'd100, 16'd7);
    repeat (7) cyc();
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        cyc();
        if (Done) seen++;
      end
      chk("mid_rst_no_done", seen, 0);
    end

    // Random back-to-back divisions, restarting on the Done cycle
    for (int i = 0; i < 500; i++) begin
      logic [15:0] a, b;
      int sel;
      sel = $urandom_range(0, 9);
      a = 16'($urandom);
      b = 16'($urandom);
      if (sel == 0) b = 16'd0;
      if (sel == 1) b = 16'hFFFF;
      if (sel == 2) a = 16'hFFFF;
      if (sel == 3) a = 16'd0;
      if (sel == 4) b = 16'($urandom_range(1, 15));
      launch(a, b);
      wait_done(b == 16'd0 ? 0 : 16);
      check_result(a, b);
    end

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
